ramb18_stream_reader: RTL and testbench

- Read-side controller for one port of the dual-port pipelined RAMB18 wrapper (write-first, 2-cycle registered read).
- Issues sequential read addresses over a configurable window and absorbs the fixed 2-cycle read latency.
- Presents the words as an AXI-Stream master with full backpressure support.
- Sits between the weight RAM and the MVAU weight input in memstream; sustains 1 word/cycle when tready stays high.

---
 rtl/ramb18_stream_reader_pkg.sv | 26 ++
 rtl/ramb18_stream_reader_if.sv | 39 +++
 rtl/ramb18_stream_reader_fifo.sv | 65 ++++++
 rtl/ramb18_stream_reader.sv | 114 +++++++++++
 tb/tb_ramb18_stream_reader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ramb18_stream_reader_pkg.sv
// ============================================================================
//  Module   : memstream_pkg
//  Brief    : Shared constants and helpers for the memstream read path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package memstream_pkg;

    // Pipelined RAMB18 read: address registered, then output register.
    localparam int RAM_RD_LATENCY = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int end_addr(input int start, input int nwords);
        return start + nwords - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ramb18_stream_reader_if.sv
// ============================================================================
//  Module   : ramb18_stream_reader_if
//  Brief    : AXI-Stream link; tlast exists only with RAMB18_STREAM_READER_TLAST_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ramb18_stream_reader_if #(
    parameter int DWIDTH = 18
) ();

    logic [DWIDTH-1:0] tdata;
    logic              tvalid;
    logic              tready;
`ifdef RAMB18_STREAM_READER_TLAST_EN
    logic              tlast;
`endif

    modport master (
`ifdef RAMB18_STREAM_READER_TLAST_EN
        output tlast,
`endif
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
`ifdef RAMB18_STREAM_READER_TLAST_EN
        input  tlast,
`endif
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

`default_nettype wire

// File: rtl/ramb18_stream_reader_fifo.sv
// ============================================================================
//  Module   : memstream_fifo
//  Brief    : Register FIFO, head entry visible combinationally on dout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memstream_fifo
    import memstream_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int c_aw = clog2(DEPTH),
    localparam int c_cw = c_aw + 1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [c_cw-1:0]  count,
    output logic             empty
);

    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO is only accepted when a pop frees the slot.
    assign w_pop  = pop & (r_count != '0);
    assign w_push = push & ((r_count != c_full) | w_pop);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ramb18_stream_reader.sv
// ============================================================================
//  Module   : ramb18_stream_reader
//  Brief    : Streams a RAMB18 address window out as AXI-Stream, absorbing the
//             2-cycle read latency. Option: RAMB18_STREAM_READER_TLAST_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ramb18_stream_reader
    import memstream_pkg::*;
#(
    parameter int DWIDTH     = 18,
    parameter int AWIDTH     = 10,
    parameter int START_ADDR = 0,
    parameter int NWORDS     = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   run,
    output logic                   ram_we,
    output logic                   ram_en,
    output logic                   ram_enq,
    output logic [AWIDTH-1:0]      ram_addr,
    input  logic [DWIDTH-1:0]      ram_rdq,
    ramb18_stream_reader_if.master m_axis
);

`ifdef RAMB18_STREAM_READER_TLAST_EN
    localparam int c_fifo_w = DWIDTH + 1;
`else
    localparam int c_fifo_w = DWIDTH;
`endif
    localparam int                c_cnt_w = clog2(FIFO_DEPTH) + 1;
    localparam logic [AWIDTH-1:0] c_start = AWIDTH'(START_ADDR);
    localparam logic [AWIDTH-1:0] c_end   = AWIDTH'(end_addr(START_ADDR, NWORDS));
    localparam logic [c_cnt_w:0]  c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

    logic                      r_enq;
    logic [AWIDTH-1:0]         r_addr;
    logic [RAM_RD_LATENCY-1:0] r_vld;
    logic [c_cnt_w:0]          w_inflight;
    logic [c_cnt_w:0]          w_used;
    logic [c_cnt_w-1:0]        w_count;
    logic                      w_issue;
    logic                      w_empty;
    logic                      w_pop;
    logic [c_fifo_w-1:0]       w_din;
    logic [c_fifo_w-1:0]       w_dout;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RAM_RD_LATENCY; i++)
            w_inflight = w_inflight + (c_cnt_w + 1)'(r_vld[i]);
    end

    // Every issued read holds a FIFO slot until popped, so the FIFO can't overflow.
    // Issue also waits for ram_enq so the RAM output register is live first.
    assign w_used  = w_inflight + {1'b0, w_count};
    assign w_issue = r_enq & run & (w_used < c_depth);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_enq  <= 1'b0;
            r_addr <= c_start;
            r_vld  <= '0;
        end else begin
            r_enq <= 1'b1;
            r_vld <= {r_vld[RAM_RD_LATENCY-2:0], w_issue};
            if (w_issue)
                r_addr <= (r_addr == c_end) ? c_start : r_addr + 1'b1;
        end
    end

`ifdef RAMB18_STREAM_READER_TLAST_EN
    logic [RAM_RD_LATENCY-1:0] r_lst;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) r_lst <= '0;
        else          r_lst <= {r_lst[RAM_RD_LATENCY-2:0], w_issue & (r_addr == c_end)};
    end

    assign w_din       = {r_lst[RAM_RD_LATENCY-1], ram_rdq};
    assign m_axis.tlast = w_dout[DWIDTH];
`else
    assign w_din = ram_rdq;
`endif

    assign w_pop = ~w_empty & m_axis.tready;

    memstream_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .push    (r_vld[RAM_RD_LATENCY-1]),
        .pop     (w_pop),
        .din     (w_din),
        .dout    (w_dout),
        .count   (w_count),
        .empty   (w_empty)
    );

    assign ram_we        = 1'b0;
    assign ram_en        = w_issue;
    assign ram_enq       = r_enq;
    assign ram_addr      = r_addr;
    assign m_axis.tdata  = w_dout[DWIDTH-1:0];
    assign m_axis.tvalid = ~w_empty;

endmodule

`default_nettype wire

// File: tb/tb_ramb18_stream_reader.sv
// ============================================================================
//  Module   : tb_ramb18_stream_reader
//  Brief    : Three reader instances (0/8, 100/3, 5/1 windows) over a modelled
//             pipelined RAM; beats scored against address-order expectation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ramb18_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aresetn = 1'b0;
    logic run     = 1'b0;
    logic tready  = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [17:0] mem [1024];
    logic        we [3], en [3], enq [3], tv [3];
    logic [9:0]  ad [3];
    logic [17:0] td [3], rdq [3], r1 [3];
`ifdef RAMB18_STREAM_READER_TLAST_EN
    logic        tl [3];
`endif

    int          beats [3], issues [3];
    int          seq_err [3], addr_err [3], stall_err [3], last_err [3], we_err [3];
    logic        prev_stall [3];
    logic [17:0] prev_td [3], last_data [3];

    function automatic int st(input int i);
        return (i == 0) ? 0 : (i == 1) ? 100 : 5;
    endfunction

    function automatic int nw(input int i);
        return (i == 0) ? 8 : (i == 1) ? 3 : 1;
    endfunction

    ramb18_stream_reader_if #(.DWIDTH(18)) ax0 ();
    ramb18_stream_reader_if #(.DWIDTH(18)) ax1 ();
    ramb18_stream_reader_if #(.DWIDTH(18)) ax2 ();

    assign ax0.tready = tready;
    assign ax1.tready = tready;
    assign ax2.tready = tready;
    assign tv[0] = ax0.tvalid;  assign td[0] = ax0.tdata;
    assign tv[1] = ax1.tvalid;  assign td[1] = ax1.tdata;
    assign tv[2] = ax2.tvalid;  assign td[2] = ax2.tdata;
`ifdef RAMB18_STREAM_READER_TLAST_EN
    assign tl[0] = ax0.tlast;
    assign tl[1] = ax1.tlast;
    assign tl[2] = ax2.tlast;
`endif

    ramb18_stream_reader #(.START_ADDR(0), .NWORDS(8)) dut0 (
        .clk(clk), .aresetn(aresetn), .run(run), .ram_we(we[0]), .ram_en(en[0]),
        .ram_enq(enq[0]), .ram_addr(ad[0]), .ram_rdq(rdq[0]), .m_axis(ax0));
    ramb18_stream_reader #(.START_ADDR(100), .NWORDS(3)) dut1 (
        .clk(clk), .aresetn(aresetn), .run(run), .ram_we(we[1]), .ram_en(en[1]),
        .ram_enq(enq[1]), .ram_addr(ad[1]), .ram_rdq(rdq[1]), .m_axis(ax1));
    ramb18_stream_reader #(.START_ADDR(5), .NWORDS(1)) dut2 (
        .clk(clk), .aresetn(aresetn), .run(run), .ram_we(we[2]), .ram_en(en[2]),
        .ram_enq(enq[2]), .ram_addr(ad[2]), .ram_rdq(rdq[2]), .m_axis(ax2));

    initial for (int i = 0; i < 1024; i++) mem[i] = 18'(i);

    // Pipelined RAM port: address stage then output register.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (en[i])  r1[i]  <= mem[ad[i]];
            if (enq[i]) rdq[i] <= r1[i];
        end
    end

    // Scoreboard: beat k of a DUT must be mem[START + k mod NWORDS].
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we[i]) we_err[i] <= we_err[i] + 1;
            if (!aresetn) begin
                beats[i]      <= 0;
                issues[i]     <= 0;
                prev_stall[i] <= 1'b0;
            end else begin
                if (tv[i] && tready) begin
                    if (td[i] !== 18'(st(i) + beats[i] % nw(i))) seq_err[i] <= seq_err[i] + 1;
`ifdef RAMB18_STREAM_READER_TLAST_EN
                    if (tl[i] !== ((beats[i] % nw(i)) == nw(i) - 1)) last_err[i] <= last_err[i] + 1;
`endif
                    last_data[i] <= td[i];
                    beats[i]     <= beats[i] + 1;
                end
                if (en[i]) begin
                    if (ad[i] !== 10'(st(i) + issues[i] % nw(i))) addr_err[i] <= addr_err[i] + 1;
                    issues[i] <= issues[i] + 1;
                end
                if (prev_stall[i] && (!tv[i] || td[i] !== prev_td[i])) stall_err[i] <= stall_err[i] + 1;
                prev_stall[i] <= tv[i] && !tready;
                prev_td[i]    <= td[i];
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (en[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en dut%0d: got %0d want 0", i, en[i]); end
            n_tests++; if (enq[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ram_enq dut%0d: got %0d want 0", i, enq[i]); end
            n_tests++; if (ad[i] !== 10'(st(i))) begin n_fail++; $display("FAIL reset_addr dut%0d: got %0d want %0d", i, ad[i], st(i)); end
            n_tests++; if (tv[i] !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid dut%0d: got %0d want 0", i, tv[i]); end
            n_tests++; if (td[i] !== 18'd0) begin n_fail++; $display("FAIL reset_tdata dut%0d: got %0d want 0", i, td[i]); end
        end
        @(posedge clk); #1 aresetn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (enq[i] !== 1'b1) begin n_fail++; $display("FAIL enq_after_reset dut%0d: got %0d want 1", i, enq[i]); end
        end
        run    = 1'b1;
        tready = 1'b1;
    endtask

    task automatic test_continuous();
        int c_en, c_tv, bubbles;
        logic [17:0] first_word;
        c_en = -1; c_tv = -1; bubbles = 0; first_word = '1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (c_en < 0 && en[0]) c_en = k;
            if (c_tv < 0 && tv[0]) begin c_tv = k; first_word = td[0]; end
        end
        n_tests++; if (c_en < 0 || c_tv - c_en != 3) begin n_fail++; $display("FAIL latency: got %0d want 3", c_tv - c_en); end
        n_tests++; if (first_word !== 18'd0) begin n_fail++; $display("FAIL first_word: got %0d want 0", first_word); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!tv[0]) bubbles++;
        end
        n_tests++; if (bubbles != 0) begin n_fail++; $display("FAIL bubbles: got %0d want 0", bubbles); end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (seq_err[i] != 0) begin n_fail++; $display("FAIL cont_seq dut%0d: got %0d errors want 0", i, seq_err[i]); end
            n_tests++; if (addr_err[i] != 0) begin n_fail++; $display("FAIL cont_addr dut%0d: got %0d errors want 0", i, addr_err[i]); end
            n_tests++; if (beats[i] < 40) begin n_fail++; $display("FAIL cont_beats dut%0d: got %0d want >=40", i, beats[i]); end
        end
    endtask

    task automatic test_backpressure();
        tready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (en[i] !== 1'b0) begin n_fail++; $display("FAIL bp_ram_en dut%0d: got %0d want 0", i, en[i]); end
            n_tests++; if (issues[i] - beats[i] != 4) begin n_fail++; $display("FAIL bp_buffered dut%0d: got %0d want 4", i, issues[i] - beats[i]); end
            n_tests++; if (stall_err[i] != 0) begin n_fail++; $display("FAIL bp_stable dut%0d: got %0d errors want 0", i, stall_err[i]); end
        end
        run    = 1'b0;
        tready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (issues[i] != beats[i]) begin n_fail++; $display("FAIL bp_drain dut%0d: got %0d beats want %0d", i, beats[i], issues[i]); end
            n_tests++; if (seq_err[i] != 0) begin n_fail++; $display("FAIL bp_seq dut%0d: got %0d errors want 0", i, seq_err[i]); end
        end
        run = 1'b1;
    endtask

    task automatic test_run_pause();
        bit found;
        int en_seen, addr_moved, b_before;
        found = 0; en_seen = 0; addr_moved = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (ad[0] == 10'd3) begin found = 1; run = 1'b0; end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL pause_reach_addr3: got 0 want 1"); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (en[0]) en_seen++;
            if (ad[0] != 10'd3) addr_moved++;
        end
        @(posedge clk); #1;
        n_tests++; if (en_seen != 0 || addr_moved != 0) begin n_fail++; $display("FAIL pause_hold: got %0d issues %0d moves want 0 0", en_seen, addr_moved); end
        n_tests++; if (issues[0] != beats[0]) begin n_fail++; $display("FAIL pause_drain: got %0d beats want %0d", beats[0], issues[0]); end
        n_tests++; if (last_data[0] !== 18'd2) begin n_fail++; $display("FAIL pause_last_word: got %0d want 2", last_data[0]); end
        b_before = beats[0];
        run = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_tests++; if (beats[0] <= b_before) begin n_fail++; $display("FAIL resume_progress: got %0d want >%0d", beats[0], b_before); end
        n_tests++; if (seq_err[0] != 0 || addr_err[0] != 0) begin n_fail++; $display("FAIL resume_order: got %0d/%0d errors want 0", seq_err[0], addr_err[0]); end
    endtask

    task automatic test_reset_mid();
        tready = 1'b0;
        repeat (6) @(posedge clk);
        #1 aresetn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (tv[i] !== 1'b0) begin n_fail++; $display("FAIL midreset_tvalid dut%0d: got %0d want 0", i, tv[i]); end
            n_tests++; if (ad[i] !== 10'(st(i))) begin n_fail++; $display("FAIL midreset_addr dut%0d: got %0d want %0d", i, ad[i], st(i)); end
        end
        @(posedge clk); #1 aresetn = 1'b1;
        tready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (beats[i] == 0) begin n_fail++; $display("FAIL restart_beats dut%0d: got 0 want >0", i); end
            n_tests++; if (seq_err[i] != 0 || addr_err[i] != 0) begin n_fail++; $display("FAIL restart_order dut%0d: got %0d/%0d errors want 0", i, seq_err[i], addr_err[i]); end
        end
    endtask

    task automatic test_random();
        int cyc;
        cyc = 0;
        while (beats[0] < 4096 && cyc < 40000) begin
            tready = 1'($urandom_range(0, 1));
            run    = ($urandom_range(0, 7) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++; if (beats[0] < 4096) begin n_fail++; $display("FAIL random_timeout: got %0d beats want 4096", beats[0]); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (seq_err[i] != 0) begin n_fail++; $display("FAIL random_seq dut%0d: got %0d errors want 0", i, seq_err[i]); end
            n_tests++; if (addr_err[i] != 0) begin n_fail++; $display("FAIL random_addr dut%0d: got %0d errors want 0", i, addr_err[i]); end
            n_tests++; if (stall_err[i] != 0) begin n_fail++; $display("FAIL random_stable dut%0d: got %0d errors want 0", i, stall_err[i]); end
            n_tests++; if (we_err[i] != 0) begin n_fail++; $display("FAIL ram_we dut%0d: got %0d writes want 0", i, we_err[i]); end
`ifdef RAMB18_STREAM_READER_TLAST_EN
            n_tests++; if (last_err[i] != 0) begin n_fail++; $display("FAIL tlast dut%0d: got %0d errors want 0", i, last_err[i]); end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            seq_err[i] = 0; addr_err[i] = 0; stall_err[i] = 0; last_err[i] = 0; we_err[i] = 0;
        end
        test_reset();
        test_continuous();
        test_backpressure();
        test_run_pause();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
